// File: rtl/noop_trap_reporter.sv
// NOOP trap reporter: counts cycles and commits, latches the first trap and emits a one-cycle report.
// Optional commit watchdog enabled by defining TRAP_WATCHDOG_EN.
module noop_trap_reporter #(
   parameter int unsigned COMMIT_W   = 2,
   parameter int unsigned WDOG_LIMIT = 5000,
   parameter logic [31:0] WDOG_CODE  = 32'hDEAD_0001
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [$clog2(COMMIT_W+1)-1:0]  commitCnt,
   input  logic [31:0]                    commitPC,
   input  logic                           trapValid,
   input  logic [31:0]                    trapCodeIn,
   input  logic [31:0]                    trapPCIn,
   output logic                           isNoopTrap,
   output logic [31:0]                    trapCode,
   output logic [31:0]                    trapPC,
   output logic [31:0]                    cycleCnt,
   output logic [31:0]                    instrCnt,
   output logic                           halted
);

   typedef enum logic [1:0] {RUN, REPORT, HALT} state_t;

   state_t      state;
   state_t      nextState;
   logic        latchEn;
   logic [31:0] latchCode;
   logic [31:0] latchPC;

`ifdef TRAP_WATCHDOG_EN
   logic [31:0] idleCnt;
   logic [31:0] lastPC;
   logic        wdogFire;

   always_ff @(posedge clk) begin
      if (reset) begin
         idleCnt <= '0;
         lastPC  <= '0;
      end else if (state == RUN) begin
         if (commitCnt != '0) begin
            idleCnt <= '0;
            lastPC  <= commitPC;
         end else begin
            idleCnt <= idleCnt + 32'd1;
         end
      end
   end

   // Fires in the cycle whose zero-commit increment would bring idleCnt to the limit.
   assign wdogFire = (state == RUN) && (commitCnt == '0) && (idleCnt == WDOG_LIMIT - 1);
`endif

   always_comb begin
      latchEn   = 1'b0;
      latchCode = trapCodeIn;
      latchPC   = trapPCIn;
      if (state == RUN) begin
         if (trapValid) begin
            latchEn = 1'b1;
`ifdef TRAP_WATCHDOG_EN
         end else if (wdogFire) begin
            latchEn   = 1'b1;
            latchCode = WDOG_CODE;
            latchPC   = lastPC;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         RUN:     if (latchEn) nextState = REPORT;
         REPORT:  nextState = HALT;
         HALT:    nextState = HALT;
         default: nextState = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycleCnt <= '0;
         instrCnt <= '0;
         trapCode <= '0;
         trapPC   <= '0;
      end else if (state == RUN) begin
         cycleCnt <= cycleCnt + 32'd1;
         instrCnt <= instrCnt + 32'(commitCnt);
         if (latchEn) begin
            trapCode <= latchCode;
            trapPC   <= latchPC;
         end
      end
   end

   always_comb begin
      isNoopTrap = (state == REPORT);
      halted     = (state != RUN);
   end

endmodule
